// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared encodings for the muldiv_seq RV32M sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_NEG_A  = 4'd1,
        S_NEG_B  = 4'd2,
        S_ITER_A = 4'd3,
        S_ITER_B = 4'd4,
        S_FIX_LO = 4'd5,
        S_FIX_HI = 4'd6,
        S_DONE   = 4'd7
    } state_e;

    localparam int XLEN    = 32;
    localparam int LATENCY = 2 * XLEN + 5;

endpackage
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Iterative RV32M multiply/divide sequencer driving a shared
//               external ALU. MULDIV_DIV0_FAST_EN shortcuts divide-by-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_op,
    input  logic [DATA_WIDTH-1:0]    req_a,
    input  logic [DATA_WIDTH-1:0]    req_b,
    input  logic                     flush,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic [OPCODE_LENGTH-1:0] alu_operation,
    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    localparam int                      c_CNT_W   = $clog2(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0]      c_LAST    = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_ADD  = OPCODE_LENGTH'(ALU_ADD);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SUB  = OPCODE_LENGTH'(ALU_SUB);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SLTU = OPCODE_LENGTH'(ALU_SLTU);

    state_e                r_state;
    state_e                w_next_state;
    muldiv_op_e            r_op;
    logic                  r_neg_a;
    logic                  r_neg_b;
    logic                  r_div0;
    logic                  r_lt;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_a_orig;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_hi;
    logic [DATA_WIDTH-1:0] r_lo;
    logic [DATA_WIDTH-1:0] r_sum;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic [c_CNT_W-1:0]    r_cnt;

    logic                  w_is_div;
    logic                  w_rem_msb;
    logic [DATA_WIDTH-1:0] w_rem;
    logic                  w_sub;
    logic [DATA_WIDTH-1:0] w_result;

    assign w_is_div   = r_op[2];
    // Restoring-divide partial remainder is 33 bits: {w_rem_msb, w_rem}
    assign w_rem_msb  = r_hi[DATA_WIDTH-1];
    assign w_rem      = {r_hi[DATA_WIDTH-2:0], r_lo[DATA_WIDTH-1]};
    assign w_sub      = w_rem_msb || !r_lt;

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;

    always_comb begin
        w_result = r_lo;
        case (r_op)
            OP_MUL:                      w_result = r_lo;
            OP_MULH, OP_MULHSU, OP_MULHU: w_result = r_hi;
            OP_DIV, OP_DIVU:             w_result = r_div0 ? '1 : r_lo;
            OP_REM, OP_REMU:             w_result = r_div0 ? r_a_orig : r_hi;
            default:                     w_result = r_lo;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        alu_operation = c_OP_ADD;
        alu_srca      = '0;
        alu_srcb      = '0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
`ifdef MULDIV_DIV0_FAST_EN
                    if (req_op[2] && (req_b == '0)) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_NEG_A;
                    end
`else
                    w_next_state = S_NEG_A;
`endif
                end
            end
            S_NEG_A: begin
                w_next_state = S_NEG_B;
                if (r_neg_a) begin
                    alu_operation = c_OP_SUB;
                    alu_srcb      = r_a_orig;
                end else begin
                    alu_srca      = r_a_orig;
                end
            end
            S_NEG_B: begin
                w_next_state = S_ITER_A;
                if (r_neg_b) begin
                    alu_operation = c_OP_SUB;
                    alu_srcb      = r_b;
                end else begin
                    alu_srca      = r_b;
                end
            end
            S_ITER_A: begin
                w_next_state = S_ITER_B;
                if (w_is_div) begin
                    alu_operation = c_OP_SLTU;
                    alu_srca      = w_rem;
                    alu_srcb      = r_b;
                end else begin
                    alu_srca      = r_hi;
                    alu_srcb      = r_lo[0] ? r_b : '0;
                end
            end
            S_ITER_B: begin
                w_next_state = (r_cnt == c_LAST) ? S_FIX_LO : S_ITER_A;
                if (w_is_div) begin
                    alu_operation = w_sub ? c_OP_SUB : c_OP_ADD;
                    alu_srca      = w_rem;
                    alu_srcb      = w_sub ? r_b : '0;
                end else begin
                    // Unsigned wrap of hi+addend shows up as sum < hi
                    alu_operation = c_OP_SLTU;
                    alu_srca      = r_sum;
                    alu_srcb      = r_hi;
                end
            end
            S_FIX_LO: begin
                w_next_state = S_FIX_HI;
                if (r_neg_a ^ r_neg_b) begin
                    alu_operation = c_OP_SUB;
                    alu_srcb      = r_lo;
                end else begin
                    alu_srca      = r_lo;
                end
            end
            S_FIX_HI: begin
                w_next_state = S_DONE;
                if (w_is_div && r_neg_a) begin
                    alu_operation = c_OP_SUB;
                    alu_srcb      = r_hi;
                end else if (!w_is_div && (r_neg_a ^ r_neg_b)) begin
                    alu_srca      = ~r_hi;
                    alu_srcb      = {{(DATA_WIDTH-1){1'b0}}, (r_lo == '0)};
                end else begin
                    alu_srca      = r_hi;
                end
            end
            S_DONE: begin
                if (r_resp_valid && resp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        if (flush) begin
            w_next_state = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= OP_MUL;
            r_neg_a      <= 1'b0;
            r_neg_b      <= 1'b0;
            r_div0       <= 1'b0;
            r_lt         <= 1'b0;
            r_resp_valid <= 1'b0;
            r_a_orig     <= '0;
            r_b          <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_sum        <= '0;
            r_resp_data  <= '0;
            r_cnt        <= '0;
        end else if (flush) begin
            r_resp_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op     <= muldiv_op_e'(req_op);
                        r_a_orig <= req_a;
                        r_b      <= req_b;
                        r_neg_a  <= req_a[DATA_WIDTH-1] &&
                                    ((req_op == OP_MULH) || (req_op == OP_MULHSU) ||
                                     (req_op == OP_DIV)  || (req_op == OP_REM));
                        r_neg_b  <= req_b[DATA_WIDTH-1] &&
                                    ((req_op == OP_MULH) || (req_op == OP_DIV) ||
                                     (req_op == OP_REM));
                        r_div0   <= req_op[2] && (req_b == '0);
                        r_hi     <= '0;
                        r_lo     <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_NEG_A: r_lo <= alu_result;
                S_NEG_B: r_b  <= alu_result;
                S_ITER_A: begin
                    if (w_is_div) begin
                        r_lt  <= alu_result[0];
                    end else begin
                        r_sum <= alu_result;
                    end
                end
                S_ITER_B: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_is_div) begin
                        r_hi <= alu_result;
                        r_lo <= {r_lo[DATA_WIDTH-2:0], w_sub};
                    end else begin
                        r_hi <= {alu_result[0], r_sum[DATA_WIDTH-1:1]};
                        r_lo <= {r_sum[0], r_lo[DATA_WIDTH-1:1]};
                    end
                end
                S_FIX_LO: r_lo <= alu_result;
                S_FIX_HI: r_hi <= alu_result;
                S_DONE: begin
                    // First DONE cycle captures the result; handshake clears valid
                    if (!r_resp_valid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= w_result;
                    end else if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
